exp4_unidade_controle: RTL

EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

---
 rtl/exp4_unidade_controle.sv | 75 +++++++
 1 files changed

// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle: Moore control unit for the memory-game round (optional ESPERA timeout via TIMEOUT_EN)
module exp4_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARACAO  = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_ERRO    = 4'hE;
  logic [3:0] estado, prox;
  logic       expira;
`ifdef TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
  localparam int TW = TIMEOUT_CICLOS > 1 ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [TW-1:0] cnt;
  // wait-cycle counter: zero outside ESPERA so every entry starts fresh
  always_ff @(posedge clock)
    cnt <= (reset || estado != ESPERA) ? '0 : cnt + 1'b1;
  assign expira = cnt == TW'(TIMEOUT_CICLOS - 1);
`else
  localparam logic TO_EN = 1'b0;
  assign expira = 1'b0;
`endif
  // state register, reset wins over every transition
  always_ff @(posedge clock)
    estado <= reset ? INICIAL : prox;
  // next-state logic; unknown codes (and D when timeout is not built) fall back to INICIAL
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:     prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  prox = ESPERA;
      ESPERA:      prox = jogada ? REGISTRA : expira ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    prox = COMPARACAO;
      COMPARACAO:  prox = !igual ? FIM_ERRO : fimC ? FIM_ACERTO : PROXIMO;
      PROXIMO:     prox = ESPERA;
      FIM_ACERTO:  prox = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:    prox = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT: prox = !TO_EN ? INICIAL : iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:     prox = INICIAL;
    endcase
  end
  // Moore outputs decoded from the current state only
  always_comb begin
    zeraC     = estado == PREPARACAO;
    zeraR     = estado == PREPARACAO;
    registraR = estado == REGISTRA;
    contaC    = estado == PROXIMO;
    acertou   = estado == FIM_ACERTO;
    timeout   = TO_EN && estado == FIM_TIMEOUT;
    errou     = estado == FIM_ERRO || timeout;
    pronto    = acertou || errou;
    db_estado = estado;
  end
endmodule
